valu_vector_sequencer: RTL and testbench
========================================

// Module: valu_vector_sequencer
// PURPOSE
// Strip-mines one vector command of VL elements into 4-lane beats for the 4xN vector ALU.
// Each beat reads operand groups from the vector register file and latches the VALU controls
// (op, rerouting select/code). The combinational VALU result is presented to writeback
// under a valid/ready handshake.
// Sits between the vector issue stage and the VALU/vector register file; one command in flight.
// PARAMETERS
// N        32  element width in bits (one VALU lane)
// MAX_VL   64  maximum vector length in elements (multiple of 4)
// ADDR_W   5   register-file group address width (one group = 4 elements = 4*N bits)
// PORTS
// clk               in   1        clock, all state on rising edge
// rst_n             in   1        asynchronous reset, active-low
// cmd_valid         in   1        command offered
// cmd_ready         out  1        command accepted when cmd_valid && cmd_ready
// cmd_op            in   4        ALU op for all beats
// cmd_reroute_sel   in   1        1 = router result, 0 = ALU result
// cmd_reroute_code  in   3        router code
// cmd_vl            in   clog2(MAX_VL)+1  element count, 0..MAX_VL
// cmd_src0/src1/dst in   ADDR_W   base group addresses
// rd_en             out  1        register-file read strobe (1-cycle read latency)
// rd_addr0/rd_addr1 out  ADDR_W   group addresses read this cycle
// ALU_op_E          out  4        to VALU
// rerouting_select  out  1        to VALU
// rerouting_code    out  3        to VALU
// wb_valid          out  1        VALU result for wb_addr is valid
// wb_ready          in   1        writeback accepts beat
// wb_addr           out  ADDR_W   destination group
// wb_mask           out  4        per-lane write enable, bit i = lane i
// busy              out  1        command in flight
// done              out  1        one-cycle pulse after last beat accepted
// BEHAVIOUR
// - Reset: FSM=IDLE; rd_en, wb_valid, busy, done=0; cmd_ready=1; ALU_op_E, rerouting_*,
//   addresses, wb_mask=0. Reset mid-command aborts it; no further wb beats.
// - States: IDLE -> ISSUE (on cmd accept, VL>0) -> DRAIN (last read issued) -> IDLE
//   (last beat accepted). A VL=0 command: IDLE -> IDLE, done pulses next cycle, no rd_en/wb_valid.
// - cmd_ready=1 only in IDLE with done=0. Command fields are latched on accept.
//   VALU control outputs are held constant from the cycle after accept until done.
// - Beats: G=ceil(VL/4), group g=0..G-1. Read of g: rd_addr1=src1+g;
//   rd_addr0=src0+g, except when rerouting_select=1: rd_addr0=src0 for every beat
//   (scalar broadcast source). Addresses wrap modulo 2^ADDR_W.
// - Pipeline: one output stage. rd_en=1 in ISSUE when stage empty or (wb_valid && wb_ready).
//   Stage becomes valid next cycle with wb_addr=dst+g. The register file holds read data
//   while rd_en=0, so a stalled beat keeps a stable VALU result.
// - Latency: accept at cycle T -> first rd_en at T+1 -> first wb_valid at T+2.
//   With wb_ready held 1: one beat per cycle; done at T+G+2.
// - wb_valid stays 1 with wb_addr/wb_mask stable until wb_ready.
// - wb_mask=4'b1111 except last beat: (VL%4==0) ? 1111 : (1<<(VL%4))-1.
// - busy=1 from cycle after accept through cycle of last wb acceptance.
//   done asserts the following cycle for exactly 1 cycle.
// - VL>MAX_VL: clamped to MAX_VL.
// TESTING
// 1 VL=8, src0=2, src1=6, dst=10, op=ADD, wb_ready=1 -> rd_addr (2,6),(3,7);
//   wb_addr 10,11 at T+2,T+3, mask 1111; done at T+4.
// 2 VL=6 -> beats 2, last wb_mask=0011; VL=4 -> single beat, mask 1111.
// 3 VL=12, wb_ready=0 for cycles T+3..T+5 -> group1 wb_valid held, no rd_en in stall;
//   resumes in order; all 3 beats delivered once each.
// 4 reroute_sel=1, code=3, VL=8, src0=4 -> rd_addr0=4 on both beats; rerouting_select=1 held to done.
// 5 VL=0 -> cmd accepted; done pulses at T+1; no rd_en/wb_valid; cmd_ready=1 at T+2.
// 6 rst_n low in ISSUE -> all outputs reset values immediately; next cmd runs normally;
//   src0=31, VL=8 -> rd_addr0 wraps to 0.

Source files
------------

// File: rtl/valu_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : valu_vector_sequencer
// Purpose  : Splits one vector command into 4-lane beats for the VALU.
// Revision : 1.0 - initial release
// ============================================================================
module valu_vector_sequencer #(
  parameter  int N       = 32,
  parameter  int MAX_VL  = 64,
  parameter  int ADDR_W  = 5,
  localparam int c_VL_W  = $clog2(MAX_VL) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic              cmd_reroute_sel,
  input  logic [2:0]        cmd_reroute_code,
  input  logic [c_VL_W-1:0] cmd_vl,
  input  logic [ADDR_W-1:0] cmd_src0,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [3:0]        ALU_op_E,
  output logic              rerouting_select,
  output logic [2:0]        rerouting_code,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [3:0]        wb_mask,
  output logic              busy,
  output logic              done
);

  if ((MAX_VL % 4) != 0 || N < 1) begin : g_param_check
    $error("valu_vector_sequencer: MAX_VL must be a multiple of 4 and N positive");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_VL_W-1:0]   r_grp;
  logic [c_VL_W-1:0]   r_last_grp;
  logic [ADDR_W-1:0]   r_src0;
  logic [ADDR_W-1:0]   r_src1;
  logic [ADDR_W-1:0]   r_dst;
  logic [3:0]          r_last_mask;

  logic [c_VL_W-1:0]   w_vl;
  logic [c_VL_W-1:0]   w_groups;
  logic [3:0]          w_tail_mask;
  logic                w_accept;
  logic                w_rd_fire;
  logic                w_wb_fire;
  logic                w_last_rd;

  assign w_vl        = (cmd_vl > c_VL_W'(MAX_VL)) ? c_VL_W'(MAX_VL) : cmd_vl;
  assign w_groups    = (w_vl + c_VL_W'(3)) >> 2;
  assign w_tail_mask = (w_vl[1:0] == 2'd0) ? 4'b1111 : 4'((4'd1 << w_vl[1:0]) - 4'd1);

  assign cmd_ready = (r_state == S_IDLE) && !done;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_wb_fire = wb_valid && wb_ready;
  // A read may only issue when the output stage is free this cycle, so the
  // stalled beat's operands stay on the register-file read port.
  assign w_rd_fire = (r_state == S_ISSUE) && (!wb_valid || wb_ready);
  assign w_last_rd = (r_grp == r_last_grp);

  assign rd_en    = w_rd_fire;
  assign rd_addr0 = rerouting_select ? r_src0 : r_src0 + ADDR_W'(r_grp);
  assign rd_addr1 = r_src1 + ADDR_W'(r_grp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_grp            <= '0;
      r_last_grp       <= '0;
      r_src0           <= '0;
      r_src1           <= '0;
      r_dst            <= '0;
      r_last_mask      <= '0;
      ALU_op_E         <= '0;
      rerouting_select <= 1'b0;
      rerouting_code   <= '0;
      wb_valid         <= 1'b0;
      wb_addr          <= '0;
      wb_mask          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            ALU_op_E         <= cmd_op;
            rerouting_select <= cmd_reroute_sel;
            rerouting_code   <= cmd_reroute_code;
            r_src0           <= cmd_src0;
            r_src1           <= cmd_src1;
            r_dst            <= cmd_dst;
            r_grp            <= '0;
            r_last_grp       <= w_groups - c_VL_W'(1);
            r_last_mask      <= w_tail_mask;
            if (w_vl != '0) begin
              r_state <= S_ISSUE;
              busy    <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_wb_fire) begin
            wb_valid <= 1'b0;
          end
          if (w_rd_fire) begin
            wb_valid <= 1'b1;
            wb_addr  <= r_dst + ADDR_W'(r_grp);
            wb_mask  <= w_last_rd ? r_last_mask : 4'b1111;
            r_grp    <= r_grp + c_VL_W'(1);
            if (w_last_rd) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_wb_fire) begin
            wb_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_valu_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_valu_vector_sequencer
// Purpose  : Directed self-checking bench for valu_vector_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_valu_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0;
  logic       cmd_reroute_sel = 1'b0;
  logic [2:0] cmd_reroute_code = '0;
  logic [6:0] cmd_vl = '0;
  logic [4:0] cmd_src0 = '0, cmd_src1 = '0, cmd_dst = '0;
  logic       rd_en;
  logic [4:0] rd_addr0, rd_addr1;
  logic [3:0] ALU_op_E;
  logic       rerouting_select;
  logic [2:0] rerouting_code;
  logic       wb_valid;
  logic       wb_ready = 1'b1;
  logic [4:0] wb_addr;
  logic [3:0] wb_mask;
  logic       busy, done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  valu_vector_sequencer #(.N(32), .MAX_VL(64), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reroute_sel(cmd_reroute_sel), .cmd_reroute_code(cmd_reroute_code),
    .cmd_vl(cmd_vl), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_dst(cmd_dst),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .ALU_op_E(ALU_op_E), .rerouting_select(rerouting_select),
    .rerouting_code(rerouting_code),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_mask(wb_mask), .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one command and returns 1ns into the cycle after the accept edge (T+1).
  task automatic issue_cmd(input logic [3:0] op, input logic sel, input logic [2:0] code,
                           input logic [6:0] vl, input logic [4:0] s0, input logic [4:0] s1,
                           input logic [4:0] d);
    int k = 0;
    while (!cmd_ready && k < 20) begin
      step();
      k++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, k);
    end
    cmd_op = op; cmd_reroute_sel = sel; cmd_reroute_code = code;
    cmd_vl = vl; cmd_src0 = s0; cmd_src1 = s1; cmd_dst = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    n_vec++;
    if ({cmd_ready, rd_en, wb_valid, busy, done} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_flags: {ready,rd_en,wb_valid,busy,done}=%b required 10000",
               {cmd_ready, rd_en, wb_valid, busy, done});
    end
    n_vec++;
    if ({ALU_op_E, rerouting_select, rerouting_code, wb_addr, wb_mask, rd_addr0, rd_addr1} !== '0) begin
      n_err++;
      $display("FAIL reset_fields: op=%h sel=%b code=%h wb_addr=%0d mask=%b rd=(%0d,%0d) required all 0",
               ALU_op_E, rerouting_select, rerouting_code, wb_addr, wb_mask, rd_addr0, rd_addr1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    wb_ready = 1'b1;
    issue_cmd(4'h1, 1'b0, 3'd0, 7'd8, 5'd2, 5'd6, 5'd10);
    n_vec++;  // T+1
    if ({rd_en, rd_addr0, rd_addr1, wb_valid, busy} !== {1'b1, 5'd2, 5'd6, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL basic_t1: rd_en=%b rd=(%0d,%0d) wb_valid=%b busy=%b required 1 (2,6) 0 1",
               rd_en, rd_addr0, rd_addr1, wb_valid, busy);
    end
    step();  // T+2
    n_vec++;
    if ({rd_en, rd_addr0, rd_addr1, wb_valid, wb_addr, wb_mask} !==
        {1'b1, 5'd3, 5'd7, 1'b1, 5'd10, 4'b1111}) begin
      n_err++;
      $display("FAIL basic_t2: rd_en=%b rd=(%0d,%0d) wb_valid=%b wb_addr=%0d mask=%b required 1 (3,7) 1 10 1111",
               rd_en, rd_addr0, rd_addr1, wb_valid, wb_addr, wb_mask);
    end
    step();  // T+3
    n_vec++;
    if ({rd_en, wb_valid, wb_addr, wb_mask, done, ALU_op_E} !== {1'b0, 1'b1, 5'd11, 4'b1111, 1'b0, 4'h1}) begin
      n_err++;
      $display("FAIL basic_t3: rd_en=%b wb_valid=%b wb_addr=%0d mask=%b done=%b op=%h required 0 1 11 1111 0 1",
               rd_en, wb_valid, wb_addr, wb_mask, done, ALU_op_E);
    end
    step();  // T+4
    n_vec++;
    if ({done, wb_valid, busy, cmd_ready} !== 4'b1000) begin
      n_err++;
      $display("FAIL basic_t4: {done,wb_valid,busy,cmd_ready}=%b required 1000",
               {done, wb_valid, busy, cmd_ready});
    end
    step();  // T+5
    n_vec++;
    if ({done, cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL basic_t5: {done,cmd_ready}=%b required 01", {done, cmd_ready});
    end
  endtask

  task automatic test_tail_mask();
    issue_cmd(4'h2, 1'b0, 3'd0, 7'd6, 5'd0, 5'd8, 5'd16);
    step();  // T+2
    n_vec++;
    if ({wb_valid, wb_addr, wb_mask} !== {1'b1, 5'd16, 4'b1111}) begin
      n_err++;
      $display("FAIL vl6_beat0: wb_valid=%b wb_addr=%0d mask=%b required 1 16 1111", wb_valid, wb_addr, wb_mask);
    end
    step();  // T+3
    n_vec++;
    if ({wb_valid, wb_addr, wb_mask} !== {1'b1, 5'd17, 4'b0011}) begin
      n_err++;
      $display("FAIL vl6_beat1: wb_valid=%b wb_addr=%0d mask=%b required 1 17 0011", wb_valid, wb_addr, wb_mask);
    end
    step();  // T+4
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL vl6_done: done=%b required 1", done);
    end
    issue_cmd(4'h3, 1'b0, 3'd0, 7'd4, 5'd1, 5'd2, 5'd3);
    step();  // T+2
    n_vec++;
    if ({wb_valid, wb_addr, wb_mask, rd_en} !== {1'b1, 5'd3, 4'b1111, 1'b0}) begin
      n_err++;
      $display("FAIL vl4_beat0: wb_valid=%b wb_addr=%0d mask=%b rd_en=%b required 1 3 1111 0",
               wb_valid, wb_addr, wb_mask, rd_en);
    end
    step();  // T+3
    n_vec++;
    if ({done, wb_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL vl4_done: {done,wb_valid}=%b required 10", {done, wb_valid});
    end
  endtask

  task automatic test_backpressure();
    // Per-cycle expectations for cycles T+1..T+8.
    logic       rdy  [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic       e_rd [8] = '{1, 1, 0, 0, 0, 1, 0, 0};
    logic [4:0] e_ra [8] = '{1, 2, 0, 0, 0, 3, 0, 0};
    logic       e_wv [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [4:0] e_wa [8] = '{0, 20, 21, 21, 21, 21, 22, 0};
    logic       e_dn [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic [4:0] got [$];
    issue_cmd(4'h4, 1'b0, 3'd0, 7'd12, 5'd1, 5'd9, 5'd20);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      wb_ready = rdy[c];
      #1;
      n_vec++;
      if ({rd_en, wb_valid, done} !== {e_rd[c], e_wv[c], e_dn[c]}) begin
        n_err++;
        $display("FAIL stall_flags_t%0d: {rd_en,wb_valid,done}=%b required %b",
                 c + 1, {rd_en, wb_valid, done}, {e_rd[c], e_wv[c], e_dn[c]});
      end
      if (e_rd[c]) begin
        n_vec++;
        if (rd_addr0 !== e_ra[c]) begin
          n_err++;
          $display("FAIL stall_rdaddr_t%0d: rd_addr0=%0d required %0d", c + 1, rd_addr0, e_ra[c]);
        end
      end
      if (e_wv[c]) begin
        n_vec++;
        if (wb_addr !== e_wa[c]) begin
          n_err++;
          $display("FAIL stall_wbaddr_t%0d: wb_addr=%0d required %0d", c + 1, wb_addr, e_wa[c]);
        end
      end
      if (wb_valid && wb_ready) got.push_back(wb_addr);
    end
    n_vec++;
    if (got.size() != 3 || got[0] !== 5'd20 || got[1] !== 5'd21 || got[2] !== 5'd22) begin
      n_err++;
      $display("FAIL stall_delivered: %0d beats accepted, required 3 (20,21,22)", got.size());
    end
    wb_ready = 1'b1;
  endtask

  task automatic test_reroute();
    issue_cmd(4'h5, 1'b1, 3'd3, 7'd8, 5'd4, 5'd12, 5'd0);
    n_vec++;  // T+1
    if ({rd_addr0, rd_addr1, rerouting_select, rerouting_code} !== {5'd4, 5'd12, 1'b1, 3'd3}) begin
      n_err++;
      $display("FAIL reroute_t1: rd=(%0d,%0d) sel=%b code=%0d required (4,12) 1 3",
               rd_addr0, rd_addr1, rerouting_select, rerouting_code);
    end
    step();  // T+2
    n_vec++;
    if ({rd_en, rd_addr0, rd_addr1} !== {1'b1, 5'd4, 5'd13}) begin
      n_err++;
      $display("FAIL reroute_t2: rd_en=%b rd=(%0d,%0d) required 1 (4,13)", rd_en, rd_addr0, rd_addr1);
    end
    step();
    step();  // T+4
    n_vec++;
    if ({done, ALU_op_E, rerouting_select, rerouting_code} !== {1'b1, 4'h5, 1'b1, 3'd3}) begin
      n_err++;
      $display("FAIL reroute_hold: done=%b op=%h sel=%b code=%0d required 1 5 1 3",
               done, ALU_op_E, rerouting_select, rerouting_code);
    end
  endtask

  task automatic test_vl_zero();
    issue_cmd(4'h6, 1'b0, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1);
    n_vec++;  // T+1
    if ({done, rd_en, wb_valid, busy, cmd_ready} !== 5'b10000) begin
      n_err++;
      $display("FAIL vl0_t1: {done,rd_en,wb_valid,busy,cmd_ready}=%b required 10000",
               {done, rd_en, wb_valid, busy, cmd_ready});
    end
    step();  // T+2
    n_vec++;
    if ({done, rd_en, wb_valid, cmd_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL vl0_t2: {done,rd_en,wb_valid,cmd_ready}=%b required 0001",
               {done, rd_en, wb_valid, cmd_ready});
    end
  endtask

  task automatic test_clamp();
    int beats = 0;
    int cyc = 1;
    logic [3:0] last_mask = '0;
    issue_cmd(4'h7, 1'b0, 3'd0, 7'd100, 5'd0, 5'd0, 5'd0);
    while (!done && cyc < 40) begin
      if (wb_valid) begin
        beats++;
        last_mask = wb_mask;
      end
      step();
      cyc++;
    end
    n_vec++;
    if (beats != 16 || cyc != 18 || last_mask !== 4'b1111) begin
      n_err++;
      $display("FAIL clamp_vl100: beats=%0d done_at=T+%0d last_mask=%b required 16 T+18 1111",
               beats, cyc, last_mask);
    end
  endtask

  task automatic test_reset_mid();
    issue_cmd(4'h8, 1'b0, 3'd0, 7'd16, 5'd0, 5'd0, 5'd5);
    step();  // T+2, in ISSUE with a beat pending
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({cmd_ready, rd_en, wb_valid, busy, done, ALU_op_E, wb_mask} !== {5'b10000, 4'h0, 4'h0}) begin
      n_err++;
      $display("FAIL midreset: ready=%b rd_en=%b wb_valid=%b busy=%b done=%b op=%h mask=%b required 1 0 0 0 0 0 0000",
               cmd_ready, rd_en, wb_valid, busy, done, ALU_op_E, wb_mask);
    end
    step();
    rst_n = 1'b1;
    step();
    n_vec++;
    if ({wb_valid, rd_en, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL midreset_abort: {wb_valid,rd_en,busy}=%b required 000", {wb_valid, rd_en, busy});
    end
    issue_cmd(4'h2, 1'b0, 3'd0, 7'd8, 5'd31, 5'd3, 5'd30);
    n_vec++;  // T+1
    if ({rd_en, rd_addr0, rd_addr1} !== {1'b1, 5'd31, 5'd3}) begin
      n_err++;
      $display("FAIL wrap_t1: rd_en=%b rd=(%0d,%0d) required 1 (31,3)", rd_en, rd_addr0, rd_addr1);
    end
    step();  // T+2
    n_vec++;
    if ({rd_en, rd_addr0, rd_addr1, wb_valid, wb_addr} !== {1'b1, 5'd0, 5'd4, 1'b1, 5'd30}) begin
      n_err++;
      $display("FAIL wrap_t2: rd_en=%b rd=(%0d,%0d) wb_valid=%b wb_addr=%0d required 1 (0,4) 1 30",
               rd_en, rd_addr0, rd_addr1, wb_valid, wb_addr);
    end
    step();  // T+3
    n_vec++;
    if ({wb_valid, wb_addr} !== {1'b1, 5'd31}) begin
      n_err++;
      $display("FAIL wrap_t3: wb_valid=%b wb_addr=%0d required 1 31", wb_valid, wb_addr);
    end
    step();  // T+4
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_done: done=%b required 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tail_mask();
    test_backpressure();
    test_reroute();
    test_vl_zero();
    test_clamp();
    test_reset_mid();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
